// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 capture path: FSM encoding, frame defaults,
// and the RGB565 -> RGB444 field mapping.
package cam_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_HI    = 2'd2;
    localparam logic [1:0] S_LO    = 2'd3;

    // Field positions within the hi/lo bytes of an RGB565 pixel
    localparam int R_MSB    = 7;
    localparam int R_LSB    = 4;
    localparam int G_HI_MSB = 2;
    localparam int G_HI_LSB = 0;
    localparam int G_LO_BIT = 7;
    localparam int B_MSB    = 4;
    localparam int B_LSB    = 1;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    function automatic rgb444_t rgb565_to_444(input logic [7:0] hi, input logic [7:0] lo);
        rgb444_t p;
        p.r = hi[R_MSB:R_LSB];
        p.g = {hi[G_HI_MSB:G_HI_LSB], lo[G_LO_BIT]};
        p.b = lo[B_MSB:B_LSB];
        return p;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser with single-cycle rise/fall pulses on the synchronised level.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic m_clock,
    input  logic p_reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // sr_q[STAGES] is the previous synchronised level, used only for edge detection
    logic [STAGES:0] sr_q;

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) sr_q <= '0;
        else          sr_q <= {sr_q[STAGES-1:0], d_i};
    end

    assign level_o = sr_q[STAGES-1];
    assign rise_o  =  sr_q[STAGES-1] & ~sr_q[STAGES];
    assign fall_o  = ~sr_q[STAGES-1] &  sr_q[STAGES];

endmodule

// File: rtl/ov7670_pixel_capture.sv
// OV7670 parallel-bus capture: resynchronises the camera bus into m_clock and pairs
// RGB565 bytes into RGB444 pixels with x/y coordinates and a one-cycle strobe.
module ov7670_pixel_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic       m_clock,
    input  logic       p_reset,
    input  logic [7:0] in_data,
    input  logic       pclk,
    input  logic       href,
    input  logic       c_vsync,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [3:0] pix_r,
    output logic [3:0] pix_g,
    output logic [3:0] pix_b,
    output logic       frame_start,
    output logic       byte_err
);

    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

    logic pe, hf, vr, href_s;
    logic pclk_lvl, pclk_fall, href_rise, vs_lvl, vs_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_pclk (
        .m_clock(m_clock), .p_reset(p_reset), .d_i(pclk),
        .level_o(pclk_lvl), .rise_o(pe), .fall_o(pclk_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_href (
        .m_clock(m_clock), .p_reset(p_reset), .d_i(href),
        .level_o(href_s), .rise_o(href_rise), .fall_o(hf)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_vsync (
        .m_clock(m_clock), .p_reset(p_reset), .d_i(c_vsync),
        .level_o(vs_lvl), .rise_o(vr), .fall_o(vs_fall)
    );

    logic unused_sync;
    assign unused_sync = &{pclk_lvl, pclk_fall, href_rise, vs_lvl, vs_fall};

    // One extra stage so the byte presented at pe was sampled just before pclk rose
    logic [SYNC_STAGES:0][7:0] data_q;
    logic [7:0]                byte_s;

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) data_q <= '0;
        else          data_q <= {data_q[SYNC_STAGES-1:0], in_data};
    end
    assign byte_s = data_q[SYNC_STAGES];

    logic [1:0] state_q, state_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic [7:0] hi_q, hi_d;
    logic       err_q, err_d;
    logic       vld_q, vld_d;
    logic       fs_q, fs_d;
    logic [9:0] px_q, px_d, py_q, py_d;
    rgb444_t    rgb_q, rgb_d;

    logic       take;
    logic [9:0] x_inc, y_adv;

    assign take  = pe & href_s;
    assign x_inc = (x_q >= H_LIM) ? H_LIM : x_q + 10'd1;
    // An empty href pulse leaves x at 0 and therefore does not consume a row
    assign y_adv = (x_q == 10'd0) ? y_q : ((y_q >= V_LIM) ? V_LIM : y_q + 10'd1);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        hi_d    = hi_q;
        err_d   = err_q;
        vld_d   = 1'b0;
        fs_d    = 1'b0;
        px_d    = px_q;
        py_d    = py_q;
        rgb_d   = rgb_q;
        if (vr) begin
            x_d     = '0;
            y_d     = '0;
            err_d   = 1'b0;
            fs_d    = 1'b1;
            state_d = S_BLANK;
        end else begin
            case (state_q)
                S_BLANK, S_HI: begin
                    if (take) begin
                        hi_d    = byte_s;
                        state_d = S_LO;
                    end else if (hf) begin
                        x_d     = '0;
                        y_d     = y_adv;
                        state_d = S_BLANK;
                    end
                end
                S_LO: begin
                    if (take) begin
                        if (x_q < H_LIM && y_q < V_LIM) begin
                            vld_d = 1'b1;
                            px_d  = x_q;
                            py_d  = y_q;
                            rgb_d = rgb565_to_444(hi_q, byte_s);
                        end
                        x_d     = x_inc;
                        state_d = S_HI;
                    end else if (hf) begin
                        err_d   = 1'b1;
                        x_d     = '0;
                        y_d     = y_adv;
                        state_d = S_BLANK;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state_q <= S_WAIT;
            x_q     <= '0;
            y_q     <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            fs_q    <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            rgb_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            fs_q    <= fs_d;
            px_q    <= px_d;
            py_q    <= py_d;
            rgb_q   <= rgb_d;
        end
    end

    assign pix_valid   = vld_q;
    assign pix_x       = px_q;
    assign pix_y       = py_q;
    assign pix_r       = rgb_q.r;
    assign pix_g       = rgb_q.g;
    assign pix_b       = rgb_q.b;
    assign frame_start = fs_q;
    assign byte_err    = err_q;

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Directed/randomised bench for ov7670_pixel_capture with a line-level pixel model.
module tb_ov7670_pixel_capture;

    localparam int H  = 16;
    localparam int V  = 4;
    localparam int SS = 2;

    logic       m_clock = 1'b0;
    logic       p_reset = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       pclk    = 1'b0;
    logic       href    = 1'b0;
    logic       c_vsync = 1'b0;
    logic       pix_valid, frame_start, byte_err;
    logic [9:0] pix_x, pix_y;
    logic [3:0] pix_r, pix_g, pix_b;

    ov7670_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_STAGES(SS)) dut (
        .m_clock(m_clock), .p_reset(p_reset), .in_data(in_data), .pclk(pclk),
        .href(href), .c_vsync(c_vsync), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_y(pix_y), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .frame_start(frame_start), .byte_err(byte_err)
    );

    always #5 m_clock = ~m_clock;

    typedef struct {
        int x;
        int y;
        int r;
        int g;
        int b;
    } pix_t;

    int   checks   = 0;
    int   errors   = 0;
    int   n_strobe = 0;
    int   fs_cnt   = 0;
    int   exp_fs   = 0;
    pix_t exp_q[$];
    pix_t mp;

    // Model of the frame: active after a vsync, current row, sticky error
    bit m_active = 1'b0;
    int m_y      = 0;
    bit m_err    = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic pix_t mkpix(input int x, input int y, input logic [7:0] hi, input logic [7:0] lo);
        pix_t p;
        int h, l;
        h   = hi;
        l   = lo;
        p.x = x;
        p.y = y;
        p.r = h / 16;
        p.g = (h % 8) * 2 + l / 128;
        p.b = (l / 2) % 16;
        return p;
    endfunction

    always @(negedge m_clock) begin
        if (frame_start === 1'b1) fs_cnt++;
        if (pix_valid === 1'b1) begin
            n_strobe++;
            if (exp_q.size() == 0) begin
                chk("spurious_strobe", 64'(pix_valid), 64'd0);
            end else begin
                mp = exp_q.pop_front();
                chk("pixel", 64'({pix_x, pix_y, pix_r, pix_g, pix_b}),
                    64'({10'(mp.x), 10'(mp.y), 4'(mp.r), 4'(mp.g), 4'(mp.b)}));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge m_clock);
    endtask

    task automatic drive_byte(input logic [7:0] b);
        in_data = b;
        cyc(4);
        pclk = 1'b1;
        cyc(4);
        pclk = 1'b0;
    endtask

    task automatic model_line(input logic [7:0] bq[$]);
        int np;
        if (!m_active) return;
        np = bq.size() / 2;
        for (int i = 0; i < np; i++)
            if (i < H && m_y < V) exp_q.push_back(mkpix(i, m_y, bq[2*i], bq[2*i+1]));
        if (bq.size() % 2 == 1) m_err = 1'b1;
        if (np > 0 && m_y < V) m_y++;
    endtask

    task automatic send_line(input logic [7:0] bq[$]);
        model_line(bq);
        @(negedge m_clock);
        href = 1'b1;
        foreach (bq[i]) drive_byte(bq[i]);
        cyc(2);
        href = 1'b0;
        cyc(10);
    endtask

    task automatic rand_line(input int nbytes);
        logic [7:0] q[$];
        for (int i = 0; i < nbytes; i++) q.push_back(8'($urandom_range(0, 255)));
        send_line(q);
    endtask

    task automatic vsync();
        m_active = 1'b1;
        m_y      = 0;
        m_err    = 1'b0;
        exp_fs++;
        c_vsync = 1'b1;
        cyc(6);
        c_vsync = 1'b0;
        cyc(6);
    endtask

    task automatic blank_href();
        href = 1'b1;
        cyc(6);
        href = 1'b0;
        cyc(10);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_start, byte_err}), 64'd0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] b0, b1, b2, b3;
        int         s0;

        // Reset state
        cyc(4);
        chk_all_zero("reset_outputs");
        p_reset = 1'b1;
        cyc(4);

        // Line before any vsync is dropped
        rand_line(8);
        chk("no_vsync_strobes", 64'(n_strobe), 64'd0);
        chk("no_vsync_fs", 64'(fs_cnt), 64'd0);

        // Primary colours
        vsync();
        q = {8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F};
        send_line(q);
        chk("prim_fs", 64'(fs_cnt), 64'(exp_fs));
        chk("prim_drained", 64'(exp_q.size()), 64'd0);
        chk("prim_hold", 64'({pix_x, pix_y, pix_r, pix_g, pix_b}), 64'({10'd2, 10'd0, 4'h0, 4'h0, 4'hF}));
        chk("prim_err", 64'(byte_err), 64'd0);

        // Three lines with gaps, blank href pulses in between
        vsync();
        rand_line(4);
        blank_href();
        rand_line(4);
        blank_href();
        rand_line(4);
        chk("lines_drained", 64'(exp_q.size()), 64'd0);
        chk("lines_last_y", 64'(pix_y), 64'd2);

        // Odd byte count
        s0 = n_strobe;
        rand_line(5);
        chk("odd_strobes", 64'(n_strobe - s0), 64'd2);
        chk("odd_err_set", 64'(byte_err), 64'(m_err));
        vsync();
        chk("odd_err_clr", 64'(byte_err), 64'(m_err));

        // Horizontal and vertical saturation
        vsync();
        s0 = n_strobe;
        rand_line(2 * (H + 3));
        chk("hsat_strobes", 64'(n_strobe - s0), 64'(H));
        chk("hsat_last_x", 64'(pix_x), 64'(H - 1));
        for (int i = 0; i < V - 1; i++) rand_line(4);
        s0 = n_strobe;
        rand_line(4);
        rand_line(6);
        chk("vsat_strobes", 64'(n_strobe - s0), 64'd0);
        chk("vsat_drained", 64'(exp_q.size()), 64'd0);

        // vsync rising together with the lo-byte pclk edge
        vsync();
        rand_line(4);
        b0 = 8'($urandom_range(0, 255));
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        b3 = 8'($urandom_range(0, 255));
        if (m_y < V) exp_q.push_back(mkpix(0, m_y, b0, b1));
        @(negedge m_clock);
        href = 1'b1;
        drive_byte(b0);
        drive_byte(b1);
        drive_byte(b2);
        in_data = b3;
        cyc(4);
        m_active = 1'b1;
        m_y      = 0;
        m_err    = 1'b0;
        exp_fs++;
        pclk    = 1'b1;
        c_vsync = 1'b1;
        cyc(4);
        pclk = 1'b0;
        cyc(2);
        href    = 1'b0;
        c_vsync = 1'b0;
        cyc(10);
        chk("coll_fs", 64'(fs_cnt), 64'(exp_fs));
        chk("coll_drained", 64'(exp_q.size()), 64'd0);
        rand_line(4);
        chk("coll_restart_y", 64'(pix_y), 64'd0);
        chk("coll_restart_x", 64'(pix_x), 64'd1);

        // Reset mid-line, frame resumes only after the next vsync
        rand_line(3);
        chk("pre_reset_err", 64'(byte_err), 64'd1);
        b0 = 8'($urandom_range(0, 255));
        b1 = 8'($urandom_range(0, 255));
        if (m_active && m_y < V) exp_q.push_back(mkpix(0, m_y, b0, b1));
        @(negedge m_clock);
        href = 1'b1;
        drive_byte(b0);
        drive_byte(b1);
        drive_byte(8'($urandom_range(0, 255)));
        p_reset  = 1'b0;
        m_active = 1'b0;
        m_err    = 1'b0;
        #1;
        chk_all_zero("midline_reset");
        cyc(3);
        p_reset = 1'b1;
        s0 = n_strobe;
        drive_byte(8'($urandom_range(0, 255)));
        drive_byte(8'($urandom_range(0, 255)));
        drive_byte(8'($urandom_range(0, 255)));
        cyc(2);
        href = 1'b0;
        cyc(10);
        rand_line(4);
        chk("post_reset_silent", 64'(n_strobe - s0), 64'd0);
        chk("post_reset_err", 64'(byte_err), 64'd0);
        vsync();
        s0 = n_strobe;
        rand_line(6);
        chk("resume_strobes", 64'(n_strobe - s0), 64'd3);
        chk("final_fs", 64'(fs_cnt), 64'(exp_fs));
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
